vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

VGA 640x480@60 Hz timing generator and pixel output stage for the game display path. It divides the system clock into a pixel strobe and runs the horizontal/vertical counters. It publishes `hCount`/`vCount`/`bright` to the board renderer, then samples the renderer's combinational `rgb` back one pixel later. Blanking and sync alignment are applied at the output register before the pins.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; valid range 1..16.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: hSync low width in pixels.
- `H_BRIGHT_START`, 144: first visible hCount.
- `H_BRIGHT_END`, 783: last visible hCount.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width in lines.
- `V_BRIGHT_START`, 35: first visible vCount.
- `V_BRIGHT_END`, 514: last visible vCount.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `rgb_in` in 12: renderer colour {R[3:0],G[3:0],B[3:0]}, combinational function of `hCount`/`vCount`/`bright`.
- `hCount` out 10: horizontal counter, 0..H_TOTAL-1, registered.
- `vCount` out 10: vertical counter, 0..V_TOTAL-1, registered.
- `bright` out 1: decode of `hCount` in [H_BRIGHT_START,H_BRIGHT_END] and `vCount` in [V_BRIGHT_START,V_BRIGHT_END].
- `pix_en` out 1: one-Clk pixel strobe.
- `frame_tick` out 1: one-Clk pulse on the last pixel of the frame.
- `hSync` out 1: active-low, registered.
- `vSync` out 1: active-low, registered.
- `vgaR` out 4: registered colour pin.
- `vgaG` out 4: registered colour pin.
- `vgaB` out 4: registered colour pin.

## Operation
- Divider: `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en`=1 when `div`==CLK_DIV-1.
  - CLK_DIV=1 → `pix_en` constantly 1 out of reset.
- Counters advance only on `pix_en`.
  - `hCount`==H_TOTAL-1 → `hCount`=0 and `vCount` increments.
  - Else `hCount`+1.
  - `vCount`==V_TOTAL-1 at line wrap → `vCount`=0.
  - Counters never exceed TOTAL-1.
- `frame_tick` = `pix_en` & (`hCount`==H_TOTAL-1) & (`vCount`==V_TOTAL-1). The renderer and game logic update the board only on this pulse.
- Output stage, loaded on `pix_en`:
  - `hSync` ← !(`hCount` < H_SYNC).
  - `vSync` ← !(`vCount` < V_SYNC).
  - {`vgaR`,`vgaG`,`vgaB`} ← `bright` ? `rgb_in` : 0.
  - Holds between strobes.
- Colour is always forced to 0 outside `bright`, regardless of `rgb_in`.
- Reset values:
  - `div`=0, `hCount`=0, `vCount`=0, so `bright`=0.
  - `pix_en`=0 unless CLK_DIV=1.
  - `frame_tick`=0.
  - `hSync`=1, `vSync`=1 (inactive).
  - `vgaR`/`vgaG`/`vgaB`=0.
- Reset mid-frame: every register returns to its reset value immediately. Counting resumes from (0,0) on the first strobe after deassertion. No partial-frame recovery.

## Timing
- `pix_en` first asserts on the CLK_DIV-th Clk edge after `Reset` deasserts. Period thereafter is exactly CLK_DIV clocks.
- Pipeline is one pixel. Counter value N is presented during pixel slot N. Syncs and colour for N appear on the pins from strobe N+1 onward, so pins are mutually aligned.
- `bright` is valid in the same cycle as the counters. `rgb_in` must settle within one Clk period.
- Line = H_TOTAL strobes. Frame = H_TOTAL*V_TOTAL strobes (420000 at defaults, 60 Hz at 25 MHz pixel rate).
- hSync low for exactly H_SYNC consecutive pixels per line. vSync low for exactly V_SYNC*H_TOTAL pixels per frame.

## Structure
- Shared package `vga_pkg`:
  - Timing constants above.
  - 12-bit colour constants RED, WHITE, GRAY, BLACK, GREEN.
  - RGB width constant.
  - Reused by the renderer.
- Sub-module `pix_clk_en`: divider, parameter CLK_DIV, output `pix_en`.
- Counter, sync decode and output register stay in the top module.

## Test plan
- Reset, then release:
  - All outputs at reset values.
  - `pix_en` pulses every 4 Clk, first on the 4th edge.
  - `hCount` reads 1 after the first strobe.
- Line wrap: at `hCount`=799, `vCount`=10 → next strobe gives `hCount`=0, `vCount`=11, `frame_tick`=0.
- Frame wrap: at `hCount`=799, `vCount`=524 → `frame_tick`=1 for exactly one Clk, then counts (0,0). Exactly 420000 strobes between successive `frame_tick`s.
- Bright edges, with `rgb_in`=12'hFFF constant:
  - `bright`=0/1/1/0 at hCount 143/144/783/784 on `vCount`=35.
  - `bright`=0 at vCount 34 and 515.
  - `vgaR`/`vgaG`/`vgaB` show F only one strobe after bright pixels, 0 elsewhere.
- Sync widths:
  - `hSync` low for 96 strobes starting one strobe after `hCount`=0.
  - `vSync` low for 1600 strobes per frame.
- Reset asserted mid-line at (400,200) for 3 Clk:
  - Outputs return to reset values asynchronously.
  - After release, count restarts from (0,0) with CLK_DIV=1 and CLK_DIV=4 builds.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colour constants and helpers,
// used by the timing generator and the board renderer.
package vga_pkg;

  localparam int CNT_W          = 10;
  localparam int RGB_W          = 12;

  localparam int H_TOTAL        = 800;
  localparam int H_SYNC         = 96;
  localparam int H_BRIGHT_START = 144;
  localparam int H_BRIGHT_END   = 783;
  localparam int V_TOTAL        = 525;
  localparam int V_SYNC         = 2;
  localparam int V_BRIGHT_START = 35;
  localparam int V_BRIGHT_END   = 514;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t RED   = 12'hF00;
  localparam rgb_t WHITE = 12'hFFF;
  localparam rgb_t GRAY  = 12'h888;
  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t GREEN = 12'h0F0;

  function automatic logic in_span(input logic [CNT_W-1:0] x,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel strobe divider: one-Clk pulse every CLK_DIV system clocks.
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  output logic pix_en
);

  localparam int         W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             div <= '0;
    else if (div == LAST)  div <= '0;
    else                   div <= div + W'(1);
  end

  // Decoded straight from div so CLK_DIV=1 strobes on every clock.
  assign pix_en = (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel counters, bright decode, and a one-pixel
// output register that keeps sync and colour pins mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int H_TOTAL        = vga_pkg::H_TOTAL,
  parameter int H_SYNC         = vga_pkg::H_SYNC,
  parameter int H_BRIGHT_START = vga_pkg::H_BRIGHT_START,
  parameter int H_BRIGHT_END   = vga_pkg::H_BRIGHT_END,
  parameter int V_TOTAL        = vga_pkg::V_TOTAL,
  parameter int V_SYNC         = vga_pkg::V_SYNC,
  parameter int V_BRIGHT_START = vga_pkg::V_BRIGHT_START,
  parameter int V_BRIGHT_END   = vga_pkg::V_BRIGHT_END
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             pix_en,
  output logic             frame_tick,
  output logic             hSync,
  output logic             vSync,
  output logic [3:0]       vgaR,
  output logic [3:0]       vgaG,
  output logic [3:0]       vgaB
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_W   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_W   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HB_S   = CNT_W'(H_BRIGHT_START);
  localparam logic [CNT_W-1:0] HB_E   = CNT_W'(H_BRIGHT_END);
  localparam logic [CNT_W-1:0] VB_S   = CNT_W'(V_BRIGHT_START);
  localparam logic [CNT_W-1:0] VB_E   = CNT_W'(V_BRIGHT_END);

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .Clk    (Clk),
    .Reset  (Reset),
    .pix_en (pix_en)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
      end else begin
        hCount <= hCount + CNT_W'(1);
      end
    end
  end

  assign bright     = in_span(hCount, HB_S, HB_E) && in_span(vCount, VB_S, VB_E);
  assign frame_tick = pix_en && (hCount == H_LAST) && (vCount == V_LAST);

  // Pins lag the counters by one pixel; rgb_in is the renderer's answer
  // to the counters it sees in this same slot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hSync                <= 1'b1;
      vSync                <= 1'b1;
      {vgaR, vgaG, vgaB}   <= BLACK;
    end else if (pix_en) begin
      hSync                <= !(hCount < HS_W);
      vSync                <= !(vCount < VS_W);
      {vgaR, vgaG, vgaB}   <= bright ? rgb_in : BLACK;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed per-slot expectations for three builds
// (small geometry /4, small geometry /1, default geometry /1).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  hc [3];
  logic [9:0]  vc [3];
  logic        br [3];
  logic        pe [3];
  logic        ft [3];
  logic        hs [3];
  logic        vs [3];
  logic [3:0]  rr [3];
  logic [3:0]  gg [3];
  logic [3:0]  bb [3];
  logic [11:0] rgb [3];

  assign rgb[0] = {hc[0][3:0], vc[0][3:0], 4'h5};
  assign rgb[1] = 12'hFFF;
  assign rgb[2] = 12'hFFF;

  vga_timing_gen #(.CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_BRIGHT_START(5),
    .H_BRIGHT_END(16), .V_TOTAL(10), .V_SYNC(2), .V_BRIGHT_START(3),
    .V_BRIGHT_END(7)) u_small4 (
    .Clk(clk), .Reset(Reset), .rgb_in(rgb[0]), .hCount(hc[0]), .vCount(vc[0]),
    .bright(br[0]), .pix_en(pe[0]), .frame_tick(ft[0]), .hSync(hs[0]),
    .vSync(vs[0]), .vgaR(rr[0]), .vgaG(gg[0]), .vgaB(bb[0]));

  vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_BRIGHT_START(5),
    .H_BRIGHT_END(16), .V_TOTAL(10), .V_SYNC(2), .V_BRIGHT_START(3),
    .V_BRIGHT_END(7)) u_small1 (
    .Clk(clk), .Reset(Reset), .rgb_in(rgb[1]), .hCount(hc[1]), .vCount(vc[1]),
    .bright(br[1]), .pix_en(pe[1]), .frame_tick(ft[1]), .hSync(hs[1]),
    .vSync(vs[1]), .vgaR(rr[1]), .vgaG(gg[1]), .vgaB(bb[1]));

  vga_timing_gen #(.CLK_DIV(1)) u_full1 (
    .Clk(clk), .Reset(Reset), .rgb_in(rgb[2]), .hCount(hc[2]), .vCount(vc[2]),
    .bright(br[2]), .pix_en(pe[2]), .frame_tick(ft[2]), .hSync(hs[2]),
    .vSync(vs[2]), .vgaR(rr[2]), .vgaG(gg[2]), .vgaB(bb[2]));

  typedef struct {
    int inst; int slot;
    int h; int v; int b; int hsy; int vsy; int col; int tick;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sc [3];
  int   edges;
  int   nt0 = 0, nt1 = 0;

  task automatic check(input string nm, input int k, input int slot,
                       input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d slot %0d: got %0h expected %0h", nm, k, slot, act, exp);
    end
  endtask

  task automatic push(input int k, input int s, input int h, input int v,
                      input int b, input int hsy, input int vsy,
                      input int col, input int tick);
    exp_t e;
    e.inst = k; e.slot = s; e.h = h; e.v = v; e.b = b;
    e.hsy = hsy; e.vsy = vsy; e.col = col; e.tick = tick;
    sb.push_back(e);
  endtask

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 3; k++) begin
      check({nm, " hCount"}, k, -1, int'(hc[k]), 0);
      check({nm, " vCount"}, k, -1, int'(vc[k]), 0);
      check({nm, " bright"}, k, -1, int'(br[k]), 0);
      check({nm, " hSync"},  k, -1, int'(hs[k]), 1);
      check({nm, " vSync"},  k, -1, int'(vs[k]), 1);
      check({nm, " rgb"},    k, -1, int'({rr[k], gg[k], bb[k]}), 0);
      check({nm, " frame_tick"}, k, -1, int'(ft[k]), 0);
      check({nm, " pix_en"}, k, -1, int'(pe[k]), (k == 0) ? 0 : 1);
    end
  endtask

  always @(posedge clk or posedge Reset)
    if (Reset) edges <= 0;
    else       edges <= edges + 1;

  // Monitor: on each pixel strobe, retire the expectations for that slot.
  always @(negedge clk) begin
    if (Reset) begin
      for (int k = 0; k < 3; k++) sc[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pe[k]) begin
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].inst == k && sb[i].slot == sc[k]) begin
              check("hCount", k, sc[k], int'(hc[k]), sb[i].h);
              check("vCount", k, sc[k], int'(vc[k]), sb[i].v);
              check("bright", k, sc[k], int'(br[k]), sb[i].b);
              check("hSync",  k, sc[k], int'(hs[k]), sb[i].hsy);
              check("vSync",  k, sc[k], int'(vs[k]), sb[i].vsy);
              check("rgb",    k, sc[k], int'({rr[k], gg[k], bb[k]}), sb[i].col);
              check("frame_tick", k, sc[k], int'(ft[k]), sb[i].tick);
              sb.delete(i);
            end
          end
          sc[k]++;
        end
      end
    end
  end

  // Strobe and frame cadence, measured in Clk edges since reset release.
  int last_pe, last_f0, last_f1;
  always @(negedge clk) begin
    if (Reset) begin
      last_pe = -1; last_f0 = -1; last_f1 = -1;
    end else begin
      if (pe[0]) begin
        if (edges < 400) begin
          if (last_pe < 0) check("pix_en first edge", 0, -1, edges, 3);
          else             check("pix_en period", 0, -1, edges - last_pe, 4);
        end
        last_pe = edges;
      end
      if (ft[0]) begin
        if (last_f0 < 0) check("frame_tick first", 0, -1, edges, 799);
        else             check("frame_tick period", 0, -1, edges - last_f0, 800);
        last_f0 = edges; nt0++;
      end
      if (ft[1]) begin
        if (last_f1 < 0) check("frame_tick first", 1, -1, edges, 199);
        else             check("frame_tick period", 1, -1, edges - last_f1, 200);
        last_f1 = edges; nt1++;
      end
    end
  end

  task automatic drain(input int bound, input string nm);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    check({nm, " scoreboard drained"}, -1, -1, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");

    // small geometry, /4: slot, h, v, bright, hSync, vSync, rgb pins, tick
    push(0,   0,  0, 0, 0, 1, 1, 0, 0);
    push(0,   1,  1, 0, 0, 0, 0, 0, 0);
    push(0,   3,  3, 0, 0, 0, 0, 0, 0);
    push(0,   4,  4, 0, 0, 1, 0, 0, 0);
    push(0,  19, 19, 0, 0, 1, 0, 0, 0);
    push(0,  20,  0, 1, 0, 1, 0, 0, 0);
    push(0,  21,  1, 1, 0, 0, 0, 0, 0);
    push(0,  39, 19, 1, 0, 1, 0, 0, 0);
    push(0,  40,  0, 2, 0, 1, 0, 0, 0);
    push(0,  41,  1, 2, 0, 0, 1, 0, 0);
    push(0,  51, 11, 2, 0, 1, 1, 0, 0);
    push(0,  64,  4, 3, 0, 1, 1, 0, 0);
    push(0,  65,  5, 3, 1, 1, 1, 0, 0);
    push(0,  66,  6, 3, 1, 1, 1, 'h535, 0);
    push(0,  76, 16, 3, 1, 1, 1, 'hF35, 0);
    push(0,  77, 17, 3, 0, 1, 1, 'h035, 0);
    push(0,  78, 18, 3, 0, 1, 1, 0, 0);
    push(0, 150, 10, 7, 1, 1, 1, 'h975, 0);
    push(0, 151, 11, 7, 1, 1, 1, 'hA75, 0);
    push(0, 170, 10, 8, 0, 1, 1, 0, 0);
    push(0, 171, 11, 8, 0, 1, 1, 0, 0);
    push(0, 199, 19, 9, 0, 1, 1, 0, 1);
    push(0, 200,  0, 0, 0, 1, 1, 0, 0);
    push(0, 201,  1, 0, 0, 0, 0, 0, 0);
    push(0, 399, 19, 9, 0, 1, 1, 0, 1);
    // small geometry, /1
    push(1,   0,  0, 0, 0, 1, 1, 0, 0);
    push(1,   1,  1, 0, 0, 0, 0, 0, 0);
    push(1,  66,  6, 3, 1, 1, 1, 'hFFF, 0);
    push(1, 199, 19, 9, 0, 1, 1, 0, 1);
    push(1, 200,  0, 0, 0, 1, 1, 0, 0);
    // default geometry, /1
    push(2,     0,   0,  0, 0, 1, 1, 0, 0);
    push(2,     1,   1,  0, 0, 0, 0, 0, 0);
    push(2,    96,  96,  0, 0, 0, 0, 0, 0);
    push(2,    97,  97,  0, 0, 1, 0, 0, 0);
    push(2,   799, 799,  0, 0, 1, 0, 0, 0);
    push(2,   800,   0,  1, 0, 1, 0, 0, 0);
    push(2,  1600,   0,  2, 0, 1, 0, 0, 0);
    push(2,  1601,   1,  2, 0, 0, 1, 0, 0);
    push(2,  8799, 799, 10, 0, 1, 1, 0, 0);
    push(2,  8800,   0, 11, 0, 1, 1, 0, 0);
    push(2, 27600, 400, 34, 0, 1, 1, 0, 0);
    push(2, 28143, 143, 35, 0, 1, 1, 0, 0);
    push(2, 28144, 144, 35, 1, 1, 1, 0, 0);
    push(2, 28145, 145, 35, 1, 1, 1, 'hFFF, 0);
    push(2, 28783, 783, 35, 1, 1, 1, 'hFFF, 0);
    push(2, 28784, 784, 35, 0, 1, 1, 'hFFF, 0);
    push(2, 28785, 785, 35, 0, 1, 1, 0, 0);

    @(posedge clk);
    #1 Reset = 1'b0;
    drain(32000, "run");

    // Mid-line reset at (10,5) of the /4 build.
    begin
      int i;
      for (i = 0; i < 1000 && !(hc[0] == 10 && vc[0] == 5); i++) @(negedge clk);
      check("reach mid-line point", 0, -1, (i < 1000) ? 1 : 0, 1);
    end
    #1 Reset = 1'b1;
    #1 chk_reset("async reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("held reset");

    push(0,   0,  0, 0, 0, 1, 1, 0, 0);
    push(0,   1,  1, 0, 0, 0, 0, 0, 0);
    push(0,  21,  1, 1, 0, 0, 0, 0, 0);
    push(1,   0,  0, 0, 0, 1, 1, 0, 0);
    push(1,   1,  1, 0, 0, 0, 0, 0, 0);
    push(1,  20,  0, 1, 0, 1, 0, 0, 0);
    push(1, 199, 19, 9, 0, 1, 1, 0, 1);
    push(1, 200,  0, 0, 0, 1, 1, 0, 0);
    push(2,   0,  0, 0, 0, 1, 1, 0, 0);
    push(2,   1,  1, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1 Reset = 1'b0;
    drain(2000, "restart");

    check("frame ticks seen", 0, -1, (nt0 >= 2) ? 1 : 0, 1);
    check("frame ticks seen", 1, -1, (nt1 >= 2) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
